// File: rtl/adc_avg_monitor_if.sv
// Avalon-MM slave bundle for the ADC averaging monitor.
// Latency: none; this is a signal bundle only.
// Backpressure: none; no waitrequest, the slave takes every access.
interface adc_avg_monitor_if;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/adc_avg_monitor.sv
// Round-robin boxcar averager for eight 12-bit ADC channels, with sticky over-threshold flags and an Avalon-MM view.
// Latency: two sync stages before sampling; avs_readdata one cycle after avs_read; oIRQ one cycle after its cause.
// Backpressure: none; every bus access completes in the cycle it is presented.
module adc_avg_monitor #(
    parameter int SAMPLE_DIV = 50,
    parameter int LOG2_AVG   = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [11:0]      iADC_ch0,
    input  logic [11:0]      iADC_ch1,
    input  logic [11:0]      iADC_ch2,
    input  logic [11:0]      iADC_ch3,
    input  logic [11:0]      iADC_ch4,
    input  logic [11:0]      iADC_ch5,
    input  logic [11:0]      iADC_ch6,
    input  logic [11:0]      iADC_ch7,
    adc_avg_monitor_if.slave avs,
    output logic             oIRQ
);
    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int ACC_W  = 12 + LOG2_AVG;
    // sample_cnt needs at least one bit even when every tick completes a window
    localparam int SC_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [SC_W-1:0]   LAST_CNT = SC_W'((1 << LOG2_AVG) - 1);
    localparam logic [TICK_W-1:0] LAST_TCK = TICK_W'(SAMPLE_DIV - 1);

    logic [11:0]       w_adc [8];
    logic [11:0]       r_sync1 [8];
    logic [11:0]       r_sync2 [8];
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [2:0]        r_ch_idx;
    logic [SC_W-1:0]   r_sample_cnt;
    logic              w_last;
    logic [ACC_W-1:0]  r_acc [8];
    logic [11:0]       w_sample;
    logic [ACC_W-1:0]  w_sum;
    logic [11:0]       w_result;
    logic              w_complete;
    logic [7:0]        w_set_new;
    logic [7:0]        w_set_over;
    logic [11:0]       r_avg [8];
    logic [11:0]       r_thr [8];
    logic [7:0]        r_new;
    logic [7:0]        r_over;
    logic [7:0]        r_irq_en;
    logic              r_enable;
    logic              r_irq;
    logic              w_wr_status;
    logic              w_wr_ctrl;
    logic              w_wr_thr;
    logic [7:0]        w_clr_new;
    logic [7:0]        w_clr_over;
    logic [31:0]       w_rdata;
    logic [31:0]       r_readdata;
    logic              w_unused_wd;

    assign w_adc[0] = iADC_ch0;
    assign w_adc[1] = iADC_ch1;
    assign w_adc[2] = iADC_ch2;
    assign w_adc[3] = iADC_ch3;
    assign w_adc[4] = iADC_ch4;
    assign w_adc[5] = iADC_ch5;
    assign w_adc[6] = iADC_ch6;
    assign w_adc[7] = iADC_ch7;

    // Two-stage capture of all channel bits; tearing between bits is averaged out.
    always_ff @(posedge iCLK) begin
        for (int i = 0; i < 8; i++) begin
            if (iRST) begin
                r_sync1[i] <= '0;
                r_sync2[i] <= '0;
            end else begin
                r_sync1[i] <= w_adc[i];
                r_sync2[i] <= r_sync1[i];
            end
        end
    end

    assign w_tick = r_enable && (r_tick_cnt == LAST_TCK);

    // Sample-rate divider; parked at zero while scanning is disabled.
    always_ff @(posedge iCLK) begin
        if (iRST || !r_enable) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_last = (r_sample_cnt == LAST_CNT);

    // Channel scanner: window position advances once all eight channels have been sampled.
    always_ff @(posedge iCLK) begin
        if (iRST || !r_enable) begin
            r_ch_idx     <= '0;
            r_sample_cnt <= '0;
        end else if (w_tick) begin
            r_ch_idx <= r_ch_idx + 3'd1;
            if (r_ch_idx == 3'd7) begin
                r_sample_cnt <= w_last ? '0 : (r_sample_cnt + SC_W'(1));
            end
        end
    end

    // The sum cannot overflow: 2^LOG2_AVG samples of at most 0xFFF fit in ACC_W bits.
    assign w_sample   = r_sync2[r_ch_idx];
    assign w_sum      = r_acc[r_ch_idx] + ACC_W'(w_sample);
    assign w_result   = w_sum[ACC_W-1:LOG2_AVG];
    assign w_complete = w_tick && w_last;
    assign w_set_new  = w_complete ? (8'b1 << r_ch_idx) : 8'b0;
    assign w_set_over = w_set_new & {8{w_result > r_thr[r_ch_idx]}};

    // Per-channel accumulators; a completing tick restarts the window at zero.
    always_ff @(posedge iCLK) begin
        for (int i = 0; i < 8; i++) begin
            if (iRST || !r_enable) begin
                r_acc[i] <= '0;
            end else if (w_tick && (r_ch_idx == 3'(i))) begin
                r_acc[i] <= w_last ? '0 : w_sum;
            end
        end
    end

    // Latest completed average per channel.
    always_ff @(posedge iCLK) begin
        for (int i = 0; i < 8; i++) begin
            if (iRST) begin
                r_avg[i] <= '0;
            end else if (w_complete && (r_ch_idx == 3'(i))) begin
                r_avg[i] <= w_result;
            end
        end
    end

    assign w_wr_status = avs.avs_write && (avs.avs_address == 5'd8);
    assign w_wr_ctrl   = avs.avs_write && (avs.avs_address == 5'd9);
    assign w_wr_thr    = avs.avs_write && (avs.avs_address[4:3] == 2'b10);
    assign w_clr_new   = w_wr_status ? avs.avs_writedata[7:0]  : 8'b0;
    assign w_clr_over  = w_wr_status ? avs.avs_writedata[15:8] : 8'b0;
    assign w_unused_wd = ^avs.avs_writedata[30:16];

    // Sticky status flags; a same-cycle set beats a write-1-to-clear.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_new  <= '0;
            r_over <= '0;
        end else begin
            r_new  <= (r_new  & ~w_clr_new)  | w_set_new;
            r_over <= (r_over & ~w_clr_over) | w_set_over;
        end
    end

    // Control register: interrupt enables and the scan enable.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_irq_en <= '0;
            r_enable <= 1'b1;
        end else if (w_wr_ctrl) begin
            r_irq_en <= avs.avs_writedata[7:0];
            r_enable <= avs.avs_writedata[31];
        end
    end

    // Thresholds; the compare above sees the value from before a same-cycle write.
    always_ff @(posedge iCLK) begin
        for (int i = 0; i < 8; i++) begin
            if (iRST) begin
                r_thr[i] <= 12'hFFF;
            end else if (w_wr_thr && (avs.avs_address[2:0] == 3'(i))) begin
                r_thr[i] <= avs.avs_writedata[11:0];
            end
        end
    end

    // Registered level interrupt.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_over & r_irq_en);
        end
    end

    // Register map decode; unmapped addresses read as zero.
    always_comb begin
        w_rdata = '0;
        if (avs.avs_address[4:3] == 2'b00) begin
            w_rdata = {20'd0, r_avg[avs.avs_address[2:0]]};
        end else if (avs.avs_address == 5'd8) begin
            w_rdata = {16'd0, r_over, r_new};
        end else if (avs.avs_address == 5'd9) begin
            w_rdata = {r_enable, 23'd0, r_irq_en};
        end else if (avs.avs_address[4:3] == 2'b10) begin
            w_rdata = {20'd0, r_thr[avs.avs_address[2:0]]};
        end
    end

    // Read data captured on a read strobe and held otherwise; reflects pre-write state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_readdata <= '0;
        end else if (avs.avs_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign avs.avs_readdata = r_readdata;
    assign oIRQ             = r_irq;
endmodule

// File: tb/tb_adc_avg_monitor.sv
// Bench for adc_avg_monitor: randomised channel stimulus against a window-level reference model.
// Latency: model predicts register contents edge by edge, reads are compared one cycle after the strobe.
// Backpressure: none on the DUT bus; the bench issues one access per cycle.
module tb_adc_avg_monitor;
    localparam int SD   = 4;
    localparam int LA   = 4;
    localparam int NAVG = 1 << LA;
    localparam int WIN  = 8 * NAVG * SD;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [11:0] adc [8];
    logic        oIRQ;
    int          n_checks = 0;
    int          n_errors = 0;

    adc_avg_monitor_if avs ();

    adc_avg_monitor #(.SAMPLE_DIV(SD), .LOG2_AVG(LA)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iADC_ch0 (adc[0]),
        .iADC_ch1 (adc[1]),
        .iADC_ch2 (adc[2]),
        .iADC_ch3 (adc[3]),
        .iADC_ch4 (adc[4]),
        .iADC_ch5 (adc[5]),
        .iADC_ch6 (adc[6]),
        .iADC_ch7 (adc[7]),
        .avs      (avs),
        .oIRQ     (oIRQ)
    );

    always #5 iCLK = ~iCLK;

    // Reference model: the scan is a sequence of ticks every SD enabled cycles, tick k
    // visits channel k%8, and each channel averages its own run of NAVG samples.
    int unsigned m_t;
    int unsigned m_sum [8];
    int unsigned m_cnt [8];
    logic [11:0] m_avg [8];
    logic [11:0] m_thr [8];
    logic [11:0] m_h1 [8];
    logic [11:0] m_h2 [8];
    logic [7:0]  m_new, m_over, m_ien;
    logic        m_en;
    logic        m_irq;

    task automatic model_edge();
        logic [7:0]  set_n, set_o, clr_n, clr_o;
        logic        irq_nx;
        int          ch;
        logic [11:0] r;
        if (iRST) begin
            m_t = 0;
            for (int i = 0; i < 8; i++) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_avg[i] = '0; m_thr[i] = 12'hFFF;
                m_h1[i] = '0; m_h2[i] = '0;
            end
            m_new = '0; m_over = '0; m_ien = '0; m_en = 1'b1; m_irq = 1'b0;
            return;
        end
        irq_nx = |(m_over & m_ien);
        set_n = '0;
        set_o = '0;
        if (m_en) begin
            if ((m_t % SD) == SD - 1) begin
                ch = int'((m_t / SD) % 8);
                m_sum[ch] += 32'(m_h2[ch]);
                m_cnt[ch]++;
                if (m_cnt[ch] == NAVG) begin
                    r = 12'(m_sum[ch] / NAVG);
                    m_avg[ch] = r;
                    set_n[ch] = 1'b1;
                    if (r > m_thr[ch]) set_o[ch] = 1'b1;
                    m_sum[ch] = 0;
                    m_cnt[ch] = 0;
                end
            end
            m_t++;
        end else begin
            m_t = 0;
            for (int i = 0; i < 8; i++) begin
                m_sum[i] = 0; m_cnt[i] = 0;
            end
        end
        clr_n = '0;
        clr_o = '0;
        if (avs.avs_write) begin
            if (avs.avs_address == 5'd8) begin
                clr_n = avs.avs_writedata[7:0];
                clr_o = avs.avs_writedata[15:8];
            end else if (avs.avs_address == 5'd9) begin
                m_ien = avs.avs_writedata[7:0];
                m_en  = avs.avs_writedata[31];
            end else if (avs.avs_address >= 5'd16 && avs.avs_address < 5'd24) begin
                m_thr[avs.avs_address[2:0]] = avs.avs_writedata[11:0];
            end
        end
        m_new  = (m_new & ~clr_n) | set_n;
        m_over = (m_over & ~clr_o) | set_o;
        m_irq  = irq_nx;
        for (int i = 0; i < 8; i++) begin
            m_h2[i] = m_h1[i];
            m_h1[i] = adc[i];
        end
    endtask

    always @(posedge iCLK) model_edge();

    function automatic logic [31:0] m_reg(input logic [4:0] a);
        if (a < 5'd8)                return {20'd0, m_avg[a[2:0]]};
        if (a == 5'd8)               return {16'd0, m_over, m_new};
        if (a == 5'd9)               return {m_en, 23'd0, m_ien};
        if (a >= 5'd16 && a < 5'd24) return {20'd0, m_thr[a[2:0]]};
        return 32'd0;
    endfunction

    function automatic logic [31:0] reset_val(input int a);
        if (a == 9)            return 32'h8000_0000;
        if (a >= 16 && a < 24) return 32'h0000_0FFF;
        return 32'd0;
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        tick_n(1);
        iRST = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic [31:0] e);
        avs.avs_address = a;
        avs.avs_read    = 1'b1;
        e = m_reg(a);
        tick_n(1);
        avs.avs_read = 1'b0;
        d = avs.avs_readdata;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] wd);
        avs.avs_address   = a;
        avs.avs_writedata = wd;
        avs.avs_write     = 1'b1;
        tick_n(1);
        avs.avs_write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        do_reset();
        n_checks++;
        if (oIRQ !== 1'b0) begin n_errors++; $display("FAIL reset_irq got %b want 0", oIRQ); end
        for (int a = 0; a < 32; a++) begin
            bus_read(5'(a), d, e);
            n_checks++;
            if (d !== reset_val(a)) begin
                n_errors++; $display("FAIL reset_reg addr=%0d got %h want %h", a, d, reset_val(a));
            end
        end
    endtask

    task automatic test_const_channels();
        logic [31:0] d, e;
        for (int n = 0; n < 8; n++) adc[n] = 12'(32'h100 * (n + 1));
        do_reset();
        tick_n(WIN + 4);
        for (int n = 0; n < 8; n++) begin
            bus_read(5'(n), d, e);
            n_checks++;
            if (d !== 32'(32'h100 * (n + 1)) || d !== e) begin
                n_errors++; $display("FAIL const_avg ch=%0d got %h want %h model %h", n, d, 32'h100 * (n + 1), e);
            end
        end
        bus_read(5'd8, d, e);
        n_checks++;
        if (d !== 32'h0000_00FF || d !== e) begin n_errors++; $display("FAIL const_status got %h want 000000ff", d); end
        bus_write(5'd8, 32'h0000_00FF);
        bus_read(5'd8, d, e);
        n_checks++;
        if (d !== 32'h0 || d !== e) begin n_errors++; $display("FAIL w1c_status got %h want 0", d); end
    endtask

    task automatic test_step_ch3();
        logic [31:0] d, e;
        for (int n = 0; n < 8; n++) adc[n] = 12'($urandom_range(0, 4095));
        adc[0] = 12'hFFF;
        adc[3] = 12'h100;
        do_reset();
        // ch3's eighth sample falls on cycle 240, its ninth on 272
        tick_n(8 * 8 * SD - 2 * SD);
        adc[3] = 12'h200;
        tick_n(WIN + 4 - (8 * 8 * SD - 2 * SD));
        bus_read(5'd3, d, e);
        n_checks++;
        if (d !== 32'h180 || d !== e) begin n_errors++; $display("FAIL step_avg3 got %h want 180 model %h", d, e); end
        bus_read(5'd0, d, e);
        n_checks++;
        if (d !== 32'hFFF || d !== e) begin n_errors++; $display("FAIL fullscale_avg0 got %h want fff model %h", d, e); end
    endtask

    task automatic test_threshold_irq();
        logic [31:0] d, e;
        logic        seen;
        for (int n = 0; n < 8; n++) adc[n] = 12'($urandom_range(0, 12'h7FF));
        adc[2] = 12'h800;
        do_reset();
        bus_write(5'd18, 32'h7FF);
        tick_n(WIN + 4);
        bus_read(5'd8, d, e);
        n_checks++;
        if ((d & 32'hFF00) !== 32'h0400 || d !== e) begin n_errors++; $display("FAIL over_bit2 got %h want over=04 model %h", d, e); end
        n_checks++;
        if (oIRQ !== 1'b0) begin n_errors++; $display("FAIL irq_masked got %b want 0", oIRQ); end
        bus_write(5'd9, 32'h8000_0004);
        n_checks++;
        if (oIRQ !== 1'b0) begin n_errors++; $display("FAIL irq_early got %b want 0", oIRQ); end
        tick_n(1);
        n_checks++;
        if (oIRQ !== 1'b1 || m_irq !== 1'b1) begin n_errors++; $display("FAIL irq_assert got %b want 1", oIRQ); end
        bus_write(5'd8, 32'h0000_0400);
        tick_n(1);
        n_checks++;
        if (oIRQ !== 1'b0) begin n_errors++; $display("FAIL irq_clear got %b want 0", oIRQ); end
        seen = 1'b0;
        for (int i = 0; i < WIN + 16 && !seen; i++) begin
            tick_n(1);
            if (oIRQ === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || m_irq !== 1'b1) begin n_errors++; $display("FAIL irq_reassert got %b want 1 (model %b)", seen, m_irq); end
    endtask

    task automatic test_disable();
        logic [31:0] d, e;
        logic [11:0] v [8];
        for (int n = 0; n < 8; n++) begin
            v[n]   = 12'($urandom_range(0, 4095));
            adc[n] = v[n];
        end
        do_reset();
        tick_n(WIN + 4);
        for (int n = 0; n < 8; n++) begin
            bus_read(5'(n), d, e);
            n_checks++;
            if (d !== {20'd0, v[n]} || d !== e) begin n_errors++; $display("FAIL pre_dis_avg ch=%0d got %h want %h", n, d, v[n]); end
        end
        adc[0] = 12'hFFF;
        tick_n(5 * 8 * SD + 8);
        bus_write(5'd9, 32'h0);
        tick_n(WIN);
        for (int n = 0; n < 8; n++) begin
            bus_read(5'(n), d, e);
            n_checks++;
            if (d !== {20'd0, v[n]} || d !== e) begin n_errors++; $display("FAIL dis_hold_avg ch=%0d got %h want %h", n, d, v[n]); end
        end
        adc[0] = 12'h010;
        bus_write(5'd9, 32'h8000_0000);
        bus_read(5'd9, d, e);
        n_checks++;
        if (d !== 32'h8000_0000) begin n_errors++; $display("FAIL ctrl_rd got %h want 80000000", d); end
        tick_n(WIN + 4);
        bus_read(5'd0, d, e);
        n_checks++;
        if (d !== 32'h010 || d !== e) begin n_errors++; $display("FAIL reen_avg0 got %h want 010 model %h", d, e); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d, e;
        int          done;
        for (int n = 0; n < 8; n++) adc[n] = 12'($urandom_range(0, 4095));
        do_reset();
        // ch0 closes its first window on tick 8*(NAVG-1), i.e. cycle SD*(8*(NAVG-1)+1)
        tick_n(SD * (8 * (NAVG - 1) + 1) - 1);
        bus_write(5'd8, 32'h0000_00FF);
        bus_read(5'd8, d, e);
        n_checks++;
        if (d !== 32'h0000_0001 || d !== e) begin n_errors++; $display("FAIL set_beats_clr got %h want 00000001", d); end
        bus_write(5'd16, 32'h123);
        bus_write(5'd9, 32'h8000_00FF);
        tick_n(100);
        do_reset();
        done = 0;
        for (int a = 0; a < 24; a++) begin
            if (a < 10 || a >= 16) begin
                bus_read(5'(a), d, e);
                done++;
                n_checks++;
                if (d !== reset_val(a)) begin n_errors++; $display("FAIL midreset_reg addr=%0d got %h want %h", a, d, reset_val(a)); end
            end
        end
        n_checks++;
        if (oIRQ !== 1'b0) begin n_errors++; $display("FAIL midreset_irq got %b want 0", oIRQ); end
        tick_n(SD * (8 * (NAVG - 1) + 1) - 1 - done);
        bus_read(5'd8, d, e);
        n_checks++;
        if (d !== 32'h0 || d !== e) begin n_errors++; $display("FAIL restart_before got %h want 0", d); end
        bus_read(5'd8, d, e);
        n_checks++;
        if (d !== 32'h1 || d !== e) begin n_errors++; $display("FAIL restart_ch0_done got %h want 1", d); end
    endtask

    task automatic test_random_windows();
        logic [31:0] d, e;
        for (int n = 0; n < 8; n++) adc[n] = 12'($urandom_range(0, 4095));
        do_reset();
        for (int n = 0; n < 8; n++) bus_write(5'(16 + n), 32'($urandom_range(0, 4095)));
        bus_write(5'd9, 32'h8000_0000 | 32'($urandom_range(0, 255)));
        for (int c = 0; c < 3 * WIN; c++) begin
            if ($urandom_range(0, 15) == 0) adc[$urandom_range(0, 7)] = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 63) == 0) bus_write(5'd8, $urandom);
            else tick_n(1);
            n_checks++;
            if (oIRQ !== m_irq) begin n_errors++; $display("FAIL rand_irq cycle=%0d got %b want %b", c, oIRQ, m_irq); end
        end
        for (int a = 0; a < 9; a++) begin
            bus_read(5'(a), d, e);
            n_checks++;
            if (d !== e) begin n_errors++; $display("FAIL rand_reg addr=%0d got %h want %h", a, d, e); end
        end
    endtask

    initial begin
        avs.avs_address   = '0;
        avs.avs_read      = 1'b0;
        avs.avs_write     = 1'b0;
        avs.avs_writedata = '0;
        for (int n = 0; n < 8; n++) adc[n] = '0;
        test_reset();
        test_const_channels();
        test_step_ch3();
        test_threshold_irq();
        test_disable();
        test_w1c_collision();
        test_random_windows();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
